// File: rtl/isa_dma_engine_if.sv
// ISA-side DMA bus bundle: ISA pins, channel configuration and the HPS RX/TX handshake.
interface isa_dma_engine_if;
  logic [3:0]  drq;
  logic        pio_busy;
  logic        cfg_load;
  logic [1:0]  cfg_channel;
  logic [15:0] cfg_count;
  logic        cfg_dir;
  logic [15:0] d_in;
  logic [15:0] d_out;
  logic        d_oe;
  logic [3:0]  dack_n;
  logic        aen;
  logic        ior_n;
  logic        iow_n;
  logic        dma_busy;
  logic [15:0] rx_data;
  logic [1:0]  rx_channel;
  logic        rx_valid;
  logic        rx_ack;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  tc;

  // DMA engine side: owns the ISA strobes and the RX/TX buffer outputs
  modport master (
    input  drq, pio_busy, cfg_load, cfg_channel, cfg_count, cfg_dir, d_in,
           rx_ack, tx_data, tx_valid,
    output d_out, d_oe, dack_n, aen, ior_n, iow_n, dma_busy,
           rx_data, rx_channel, rx_valid, tx_ready, tc
  );

  // Surrounding logic: ISA pins, PIO arbitration and the HPS register file
  modport slave (
    output drq, pio_busy, cfg_load, cfg_channel, cfg_count, cfg_dir, d_in,
           rx_ack, tx_data, tx_valid,
    input  d_out, d_oe, dack_n, aen, ior_n, iow_n, dma_busy,
           rx_data, rx_channel, rx_valid, tx_ready, tc
  );
endinterface

// File: rtl/isa_dma_engine.sv
// ISA DMA cycle sequencer: single-transfer cycles between the ISA bus and a
// one-entry RX/TX buffer, with per-channel transfer counters and terminal count.
module isa_dma_engine #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 3
) (
  input  logic           clk,
  input  logic           reset,
  isa_dma_engine_if.master bus
);

  localparam int unsigned NCH   = 4;
  localparam int unsigned MAXPH = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int unsigned PH_W  = (MAXPH > 1) ? $clog2(MAXPH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RELEASE
  } state_t;

  state_t          state_q;
  logic [PH_W-1:0] ph_q;
  logic [1:0]      ch_q;
  logic [15:0]     cnt_q [NCH];
  logic [3:0]      dir_q;
  logic [3:0]      en_q;
  logic [3:0]      sync_q [SYNC_STAGES];

  logic [15:0] d_out_q;
  logic        d_oe_q;
  logic [3:0]  dack_n_q;
  logic        aen_q;
  logic        ior_n_q;
  logic        iow_n_q;
  logic        dma_busy_q;
  logic [15:0] rx_data_q;
  logic [1:0]  rx_channel_q;
  logic        rx_valid_q;
  logic        tx_ready_q;
  logic [3:0]  tc_q;

  logic [3:0]  drq_sync;
  logic [3:0]  elig;
  logic [1:0]  ch_next;

  assign drq_sync = sync_q[SYNC_STAGES-1];

  // DRQ synchroniser chain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= 4'h0;
    end else begin
      sync_q[0] <= bus.drq;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Channel eligibility and fixed priority (ch0 wins)
  always_comb begin
    ch_next = 2'd0;
    for (int n = 0; n < int'(NCH); n++) begin
      elig[n] = en_q[n] & drq_sync[n] & (dir_q[n] ? bus.tx_valid : !rx_valid_q);
    end
    for (int n = int'(NCH) - 1; n >= 0; n--) begin
      if (elig[n]) ch_next = 2'(n);
    end
  end

  // Cycle sequencer, channel configuration and buffer handshakes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ph_q         <= '0;
      ch_q         <= 2'd0;
      for (int n = 0; n < int'(NCH); n++) cnt_q[n] <= 16'd0;
      dir_q        <= 4'h0;
      en_q         <= 4'h0;
      d_out_q      <= 16'd0;
      d_oe_q       <= 1'b0;
      dack_n_q     <= 4'hF;
      aen_q        <= 1'b0;
      ior_n_q      <= 1'b1;
      iow_n_q      <= 1'b1;
      dma_busy_q   <= 1'b0;
      rx_data_q    <= 16'd0;
      rx_channel_q <= 2'd0;
      rx_valid_q   <= 1'b0;
      tx_ready_q   <= 1'b0;
      tc_q         <= 4'h0;
    end else begin
      tx_ready_q <= 1'b0;
      tc_q       <= 4'h0;

      if (bus.rx_ack && rx_valid_q) rx_valid_q <= 1'b0;

      // A load aimed at the channel currently on the bus is dropped
      if (bus.cfg_load && !(dma_busy_q && (bus.cfg_channel == ch_q))) begin
        cnt_q[bus.cfg_channel] <= bus.cfg_count;
        dir_q[bus.cfg_channel] <= bus.cfg_dir;
        en_q[bus.cfg_channel]  <= (bus.cfg_count != 16'd0);
      end

      case (state_q)
        S_IDLE: begin
          if (!bus.pio_busy && (|elig)) begin
            state_q    <= S_SETUP;
            ch_q       <= ch_next;
            ph_q       <= PH_W'(SETUP_CYCLES - 1);
            dma_busy_q <= 1'b1;
            aen_q      <= 1'b1;
            dack_n_q   <= ~(4'b0001 << ch_next);
            if (dir_q[ch_next]) begin
              d_oe_q  <= 1'b1;
              d_out_q <= ch_next[1] ? bus.tx_data : {8'h00, bus.tx_data[7:0]};
            end
          end
        end
        S_SETUP: begin
          if (ph_q == '0) begin
            state_q <= S_STROBE;
            ph_q    <= PH_W'(STROBE_CYCLES - 1);
            if (dir_q[ch_q]) iow_n_q <= 1'b0;
            else             ior_n_q <= 1'b0;
          end else begin
            ph_q <= ph_q - PH_W'(1);
          end
        end
        S_STROBE: begin
          if (ph_q == '0) begin
            state_q <= S_HOLD;
            ior_n_q <= 1'b1;
            iow_n_q <= 1'b1;
            if (dir_q[ch_q]) begin
              tx_ready_q <= 1'b1;
            end else begin
              rx_data_q    <= ch_q[1] ? bus.d_in : {8'h00, bus.d_in[7:0]};
              rx_channel_q <= ch_q;
              rx_valid_q   <= 1'b1;
            end
          end else begin
            ph_q <= ph_q - PH_W'(1);
          end
        end
        S_HOLD: begin
          state_q  <= S_RELEASE;
          dack_n_q <= 4'hF;
          aen_q    <= 1'b0;
          d_oe_q   <= 1'b0;
          d_out_q  <= 16'd0;
        end
        S_RELEASE: begin
          state_q      <= S_IDLE;
          dma_busy_q   <= 1'b0;
          cnt_q[ch_q]  <= cnt_q[ch_q] - 16'd1;
          if (cnt_q[ch_q] == 16'd1) begin
            tc_q[ch_q] <= 1'b1;
            en_q[ch_q] <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.d_out      = d_out_q;
  assign bus.d_oe       = d_oe_q;
  assign bus.dack_n     = dack_n_q;
  assign bus.aen        = aen_q;
  assign bus.ior_n      = ior_n_q;
  assign bus.iow_n      = iow_n_q;
  assign bus.dma_busy   = dma_busy_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_channel = rx_channel_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.tx_ready   = tx_ready_q;
  assign bus.tc         = tc_q;

endmodule

// File: tb/tb_isa_dma_engine.sv
// Directed self-checking bench for isa_dma_engine (default parameters).
module tb_isa_dma_engine;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  isa_dma_engine_if bus();

  isa_dma_engine #(
    .SYNC_STAGES  (2),
    .SETUP_CYCLES (1),
    .STROBE_CYCLES(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Bounded wait for aen; returns the number of clocks taken (budget on timeout)
  task automatic wait_aen(input int budget, output int n);
    n = 0;
    while (bus.aen !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [15:0] count, input logic dir);
    bus.cfg_load    = 1'b1;
    bus.cfg_channel = ch;
    bus.cfg_count   = count;
    bus.cfg_dir     = dir;
    tick();
    bus.cfg_load    = 1'b0;
  endtask

  // Clocks over which aen is seen high
  task automatic count_aen(input int cycles, output int hits);
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.aen === 1'b1) hits++;
    end
  endtask

  initial begin
    int n;
    int hits;
    int ior_lo;
    int iow_lo;
    int txr;
    int rises;
    int start2;
    int tc_t;
    int tc_cnt;
    logic prev_aen;

    n_cmp = 0;
    n_bad = 0;
    clk   = 1'b0;
    reset = 1'b0;
    bus.drq         = 4'hF;
    bus.pio_busy    = 1'b0;
    bus.cfg_load    = 1'b0;
    bus.cfg_channel = 2'd0;
    bus.cfg_count   = 16'd0;
    bus.cfg_dir     = 1'b0;
    bus.d_in        = 16'd0;
    bus.rx_ack      = 1'b0;
    bus.tx_data     = 16'd0;
    bus.tx_valid    = 1'b0;

    // Reset held with all DRQs high
    tick_n(3);
    chk("rst_dack_n", 32'(bus.dack_n), 32'hF);
    chk("rst_aen", 32'(bus.aen), 32'h0);
    chk("rst_ior_n", 32'(bus.ior_n), 32'h1);
    chk("rst_iow_n", 32'(bus.iow_n), 32'h1);
    chk("rst_busy", 32'(bus.dma_busy), 32'h0);
    chk("rst_tc", 32'(bus.tc), 32'h0);

    // Released but nothing configured: stays idle
    reset = 1'b1;
    count_aen(8, hits);
    chk("unconfig_no_cycle", 32'(hits), 32'h0);

    // Single read on ch2
    bus.drq  = 4'b0100;
    bus.d_in = 16'hBEEF;
    tick_n(3);
    cfg(2'd2, 16'd1, 1'b0);
    wait_aen(10, n);
    chk("rd_start_lat", 32'(n), 32'd1);
    chk("rd_dack_n", 32'(bus.dack_n), 32'hB);
    chk("rd_setup_ior_n", 32'(bus.ior_n), 32'h1);
    chk("rd_setup_busy", 32'(bus.dma_busy), 32'h1);
    chk("rd_setup_oe", 32'(bus.d_oe), 32'h0);
    ior_lo = 0;
    iow_lo = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.ior_n === 1'b0) ior_lo++;
      if (bus.iow_n === 1'b0) iow_lo++;
    end
    chk("rd_ior_lo_cycles", 32'(ior_lo), 32'd3);
    chk("rd_iow_never", 32'(iow_lo), 32'd0);
    tick(); // HOLD
    chk("rd_hold_ior_n", 32'(bus.ior_n), 32'h1);
    chk("rd_hold_dack_n", 32'(bus.dack_n), 32'hB);
    chk("rd_rx_valid", 32'(bus.rx_valid), 32'h1);
    chk("rd_rx_data", 32'(bus.rx_data), 32'hBEEF);
    chk("rd_rx_channel", 32'(bus.rx_channel), 32'd2);
    tick(); // RELEASE
    chk("rd_rel_dack_n", 32'(bus.dack_n), 32'hF);
    chk("rd_rel_aen", 32'(bus.aen), 32'h0);
    chk("rd_rel_busy", 32'(bus.dma_busy), 32'h1);
    tick(); // IDLE
    chk("rd_idle_busy", 32'(bus.dma_busy), 32'h0);
    chk("rd_tc", 32'(bus.tc), 32'h4);
    bus.rx_ack = 1'b1;
    tick();
    bus.rx_ack = 1'b0;
    chk("rd_tc_pulse", 32'(bus.tc), 32'h0);
    chk("rd_rx_cleared", 32'(bus.rx_valid), 32'h0);
    count_aen(10, hits);
    chk("rd_no_second", 32'(hits), 32'h0);

    // Two 8-bit writes on ch0
    bus.drq      = 4'b0001;
    bus.tx_data  = 16'h12A5;
    bus.tx_valid = 1'b1;
    tick_n(3);
    cfg(2'd0, 16'd2, 1'b1);
    wait_aen(10, n);
    chk("wr_start_lat", 32'(n), 32'd1);
    chk("wr_dack_n", 32'(bus.dack_n), 32'hE);
    chk("wr_d_out", 32'(bus.d_out), 32'h00A5);
    chk("wr_d_oe", 32'(bus.d_oe), 32'h1);
    ior_lo = 0; iow_lo = 0; txr = 0; rises = 0; start2 = -1; tc_t = -1; tc_cnt = 0;
    prev_aen = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (bus.ior_n === 1'b0) ior_lo++;
      if (bus.iow_n === 1'b0) iow_lo++;
      if (bus.tx_ready === 1'b1) txr++;
      if (bus.aen === 1'b1 && prev_aen === 1'b0) begin
        rises++;
        start2 = t;
      end
      if (bus.tc[0] === 1'b1) begin
        tc_cnt++;
        tc_t = t;
      end
      if (t == 4) chk("wr_hold_oe", 32'(bus.d_oe), 32'h1);
      prev_aen = bus.aen;
    end
    chk("wr_start_spacing", 32'(start2), 32'd7);
    chk("wr_cycles", 32'(rises), 32'd1);
    chk("wr_iow_lo_cycles", 32'(iow_lo), 32'd6);
    chk("wr_ior_never", 32'(ior_lo), 32'd0);
    chk("wr_tx_ready_pulses", 32'(txr), 32'd2);
    chk("wr_tc_count", 32'(tc_cnt), 32'd1);
    chk("wr_tc_time", 32'(tc_t), 32'd13);
    bus.tx_valid = 1'b0;
    bus.drq      = 4'b0000;

    // ch1 and ch3 reads, configured under pio_busy
    bus.pio_busy = 1'b1;
    bus.d_in     = 16'h3377;
    bus.drq      = 4'b1010;
    cfg(2'd1, 16'd5, 1'b0);
    cfg(2'd3, 16'd5, 1'b0);
    count_aen(5, hits);
    chk("pio_gate", 32'(hits), 32'h0);
    bus.pio_busy = 1'b0;
    wait_aen(10, n);
    chk("pio_drop_lat", 32'(n), 32'd1);
    chk("prio_dack_n", 32'(bus.dack_n), 32'hD);
    tick_n(6);
    chk("prio_rx_valid", 32'(bus.rx_valid), 32'h1);
    chk("prio_rx_channel", 32'(bus.rx_channel), 32'd1);
    chk("prio_rx_data", 32'(bus.rx_data), 32'h0077);
    count_aen(12, hits);
    chk("stall_no_cycle", 32'(hits), 32'h0);
    bus.rx_ack = 1'b1;
    tick();
    bus.rx_ack = 1'b0;
    wait_aen(10, n);
    chk("ack_restart_lat", 32'(n), 32'd1);
    chk("ack_ch1_again", 32'(bus.dack_n), 32'hD);
    tick_n(6);
    chk("ack_rx_valid", 32'(bus.rx_valid), 32'h1);

    // Reset during STROBE of another ch1 read
    bus.rx_ack = 1'b1;
    tick();
    bus.rx_ack = 1'b0;
    wait_aen(10, n);
    chk("mid_start_lat", 32'(n), 32'd1);
    tick();
    chk("mid_in_strobe", 32'(bus.ior_n), 32'h0);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_ior_n", 32'(bus.ior_n), 32'h1);
    chk("mid_rst_dack_n", 32'(bus.dack_n), 32'hF);
    chk("mid_rst_aen", 32'(bus.aen), 32'h0);
    chk("mid_rst_busy", 32'(bus.dma_busy), 32'h0);
    chk("mid_rst_rx_valid", 32'(bus.rx_valid), 32'h0);
    tick_n(2);
    reset = 1'b1;
    count_aen(12, hits);
    chk("mid_counts_cleared", 32'(hits), 32'h0);
    chk("mid_rx_stays_clear", 32'(bus.rx_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
